// File: rtl/demux_1x4_if.sv
// demux_1x4_if -- bundle of the inbound beat stream, the four outbound
// streams and the packet-open status of the 1-to-4 packet demultiplexer.
//
// Parameter:
//   WIDTH   data beat width in bits
// Signals:
//   i0, i_valid, i_last, i_ready   inbound beat handshake
//   s1, s0                         destination select (00->o0 .. 11->o3)
//   o0..o3                         outbound data per destination
//   o_valid, o_last, o_ready       outbound handshake, bit n belongs to on
//   busy                           a multi-beat packet is open
// Modports:
//   master  traffic source / sink side (testbench or surrounding logic)
//   slave   the demultiplexer itself
interface demux_1x4_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] i0;
  logic             i_valid;
  logic             i_last;
  logic             i_ready;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [3:0]       o_valid;
  logic [3:0]       o_last;
  logic [3:0]       o_ready;
  logic             busy;

  modport master (
    output i0, i_valid, i_last, s1, s0, o_ready,
    input  i_ready, o0, o1, o2, o3, o_valid, o_last, busy
  );

  modport slave (
    input  i0, i_valid, i_last, s1, s0, o_ready,
    output i_ready, o0, o1, o2, o3, o_valid, o_last, busy
  );

endinterface

// File: rtl/demux_1x4.sv
// demux_1x4 -- packet-aware 1-to-4 demultiplexer with one register slot per
// destination. A packet is routed as a whole: its destination is chosen on
// the first beat and held until the beat carrying i_last is accepted.
//
// Parameter:
//   WIDTH   data beat width in bits (must match the interface WIDTH)
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     demux_1x4_if.slave (inbound beat, four outbound slots, busy)
//
// Configuration macro:
//   DEMUX_1X4_RR_EN  when defined, s1/s0 are ignored and each new packet
//                    goes to the next destination of a 2-bit round-robin
//                    pointer (o0, o1, o2, o3, o0, ...). When undefined the
//                    destination comes from {s1,s0}.
module demux_1x4 #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  demux_1x4_if.slave bus
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  state_t           state_q;
  logic [1:0]       dest_q;
  logic             busy_q;

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       last_q;
  logic [3:0]       last_d;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;

  logic [1:0]       new_dest;
  logic [1:0]       dest;
  logic             accept;

  // Destination offered to a packet that starts this cycle.
`ifdef DEMUX_1X4_RR_EN
  logic [1:0] rr_q;
  logic       unused_sel;

  assign new_dest   = rr_q;
  assign unused_sel = bus.s1 ^ bus.s0;
`else
  assign new_dest = {bus.s1, bus.s0};
`endif

  // Once a packet is open every later beat follows the latched destination,
  // so select changes mid-packet cannot split it.
  assign dest = (state_q == PKT) ? dest_q : new_dest;

  // Only the targeted slot gates the inbound stream; a stalled consumer on
  // another output never blocks this packet.
  assign bus.i_ready = ~valid_q[dest] | bus.o_ready[dest];
  assign accept      = bus.i_valid & bus.i_ready;

  // Packet tracking: IDLE opens a packet on a non-final beat, PKT closes it
  // on the final beat. busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= 2'b00;
      busy_q  <= 1'b0;
`ifdef DEMUX_1X4_RR_EN
      rr_q    <= 2'b00;
`endif
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.i_last) begin
`ifdef DEMUX_1X4_RR_EN
            rr_q <= rr_q + 2'd1;
`endif
          end else begin
            state_q <= PKT;
            dest_q  <= new_dest;
            busy_q  <= 1'b1;
          end
        end
        PKT: begin
          if (bus.i_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef DEMUX_1X4_RR_EN
            rr_q    <= rr_q + 2'd1;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Slot update: a load wins over a drain, which gives back-to-back refill
  // without a bubble. A drained slot clears its last flag with its valid.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      data_d[n]  = data_q[n];
      last_d[n]  = last_q[n];
      valid_d[n] = valid_q[n];
      if (accept && (dest == 2'(n))) begin
        data_d[n]  = bus.i0;
        last_d[n]  = bus.i_last;
        valid_d[n] = 1'b1;
      end else if (valid_q[n] && bus.o_ready[n]) begin
        last_d[n]  = 1'b0;
        valid_d[n] = 1'b0;
      end
    end
  end

  // Slot registers, all cleared by reset so no stale beat survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= '0;
      end
      last_q  <= 4'b0000;
      valid_q <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= data_d[n];
      end
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o0      = data_q[0];
  assign bus.o1      = data_q[1];
  assign bus.o2      = data_q[2];
  assign bus.o3      = data_q[3];
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_demux_1x4.sv
// tb_demux_1x4 -- self-checking bench for demux_1x4. A reference model of
// four one-deep buffers plus a packet-open flag predicts every output; the
// directed scenarios and a randomized run are compared against it.
// Honours DEMUX_1X4_RR_EN the same way as the design.
module tb_demux_1x4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_1x4_if #(.WIDTH(8)) bus ();

  demux_1x4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock; inputs change and outputs are sampled on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state and the inputs currently being driven.
  logic [3:0] mFull;
  logic [3:0] mLast;
  logic [7:0] mData [4];
  logic       mOpen;
  logic [1:0] mDest;
  logic [1:0] mRr;
  logic       cV;
  logic [7:0] cD;
  logic       cL;
  logic [1:0] cSel;
  logic [3:0] cRdy;

  task automatic resetModel();
    mFull = 4'b0000;
    mLast = 4'b0000;
    for (int n = 0; n < 4; n++) mData[n] = 8'h00;
    mOpen = 1'b0;
    mDest = 2'b00;
    mRr   = 2'b00;
  endtask

  function automatic logic [1:0] expDest();
    if (mOpen) return mDest;
`ifdef DEMUX_1X4_RR_EN
    return mRr;
`else
    return cSel;
`endif
  endfunction

  function automatic logic expReady();
    logic [1:0] d;
    d = expDest();
    return !mFull[d] || cRdy[d];
  endfunction

  function automatic logic [7:0] outData(input int n);
    case (n)
      0:       return bus.o0;
      1:       return bus.o1;
      2:       return bus.o2;
      default: return bus.o3;
    endcase
  endfunction

  // Drive one cycle of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic [1:0] sel, input logic [3:0] rdy);
    cV   = v;
    cD   = d;
    cL   = l;
    cSel = sel;
    cRdy = rdy;
    bus.i_valid = v;
    bus.i0      = d;
    bus.i_last  = l;
    bus.s1      = sel[1];
    bus.s0      = sel[0];
    bus.o_ready = rdy;
    #1;
  endtask

  // Move the model across the next rising edge, then wait for the negedge.
  task automatic advanceModel();
    logic [1:0] d;
    logic       acc;
    d   = expDest();
    acc = cV && expReady();
    for (int n = 0; n < 4; n++) begin
      if (acc && (d == 2'(n))) begin
        mFull[n] = 1'b1;
        mLast[n] = cL;
        mData[n] = cD;
      end else if (mFull[n] && cRdy[n]) begin
        mFull[n] = 1'b0;
      end
    end
    if (acc) begin
      if (cL) begin
        mOpen = 1'b0;
        mRr   = mRr + 2'd1;
      end else if (!mOpen) begin
        mOpen = 1'b1;
        mDest = d;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 2'b11, 4'b0000);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 4'b0000 || bus.o_last !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid=%b last=%b busy=%b expected 0000 0000 0", bus.o_valid, bus.o_last, bus.busy);
    end
    checks++;
    if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00000000", {bus.o0, bus.o1, bus.o2, bus.o3});
    end
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", bus.i_ready);
    end
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    applyStimulus(1'b1, 8'hA5, 1'b1, 2'b10, 4'b1111);
    advanceModel();
    applyStimulus(1'b0, 8'h00, 1'b0, 2'b10, 4'b1111);
    checks++;
    if (bus.o2 !== 8'hA5 || bus.o_valid !== 4'b0100 || bus.o_last !== 4'b0100 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_beat: got o2=%h valid=%b last=%b busy=%b expected a5 0100 0100 0", bus.o2, bus.o_valid, bus.o_last, bus.busy);
    end
    advanceModel();
  endtask

  task automatic test_multi_beat();
    logic [7:0] beats [3];
    logic [1:0] sels  [3];
    beats = '{8'h11, 8'h22, 8'h33};
    sels  = '{2'b01, 2'b11, 2'b11};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, beats[k], (k == 2), sels[k], 4'b1111);
      advanceModel();
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b11, 4'b1111);
      checks++;
      if (bus.o1 !== beats[k] || bus.o_valid !== 4'b0010 || bus.busy !== (k != 2)) begin
        errors++;
        $display("[TB] FAIL multi_beat_%0d: got o1=%h valid=%b busy=%b expected %h 0010 %b", k, bus.o1, bus.o_valid, bus.busy, beats[k], (k != 2));
      end
    end
    checks++;
    if (bus.o_last !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL multi_beat_last: got %b expected 0010", bus.o_last);
    end
    advanceModel();
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'hAA, 1'b1, 2'b00, 4'b1110);
    advanceModel();
    applyStimulus(1'b1, 8'hBB, 1'b1, 2'b00, 4'b1110);
    checks++;
    if (bus.i_ready !== 1'b0 || bus.o0 !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL stall_hold: got ready=%b o0=%h expected 0 aa", bus.i_ready, bus.o0);
    end
    advanceModel();
    applyStimulus(1'b1, 8'hBB, 1'b1, 2'b00, 4'b1111);
    checks++;
    if (bus.i_ready !== 1'b1 || bus.o0 !== 8'hAA || bus.o_valid[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_still: got ready=%b o0=%h v=%b expected 1 aa 1", bus.i_ready, bus.o0, bus.o_valid[0]);
    end
    advanceModel();
    applyStimulus(1'b1, 8'hCC, 1'b1, 2'b00, 4'b1111);
    checks++;
    if (bus.o0 !== 8'hBB || bus.o_valid[0] !== 1'b1 || bus.i_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL refill_1: got o0=%h v=%b ready=%b expected bb 1 1", bus.o0, bus.o_valid[0], bus.i_ready);
    end
    advanceModel();
    applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'b1111);
    checks++;
    if (bus.o0 !== 8'hCC || bus.o_valid[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL refill_2: got o0=%h v=%b expected cc 1", bus.o0, bus.o_valid[0]);
    end
    advanceModel();
    checks++;
    if (bus.o_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL refill_drain: got %b expected 0000", bus.o_valid);
    end
  endtask

  task automatic test_independent_drain();
    logic [7:0] beats [2];
    beats = '{8'h01, 8'h02};
    applyStimulus(1'b1, 8'h3C, 1'b1, 2'b11, 4'b0111);
    advanceModel();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, beats[k], (k == 1), 2'b00, 4'b0111);
      checks++;
      if (bus.i_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL indep_ready_%0d: got %b expected 1", k, bus.i_ready);
      end
      advanceModel();
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'b0111);
      checks++;
      if (bus.o0 !== beats[k] || bus.o3 !== 8'h3C || bus.o_valid !== 4'b1001) begin
        errors++;
        $display("[TB] FAIL indep_flow_%0d: got o0=%h o3=%h valid=%b expected %h 3c 1001", k, bus.o0, bus.o3, bus.o_valid, beats[k]);
      end
    end
    advanceModel();
    applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'b1111);
    advanceModel();
    checks++;
    if (bus.o_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL indep_release: got %b expected 0000", bus.o_valid);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 8'h77, 1'b0, 2'b10, 4'b0000);
    advanceModel();
    applyStimulus(1'b1, 8'h78, 1'b0, 2'b10, 4'b0000);
    checks++;
    if (bus.busy !== 1'b1 || bus.o_valid !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL areset_pre: got busy=%b valid=%b expected 1 0100", bus.busy, bus.o_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.o2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL areset_now: got valid=%b busy=%b o2=%h expected 0000 0 00", bus.o_valid, bus.busy, bus.o2);
    end
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b1, 2'b01, 4'b1111);
    advanceModel();
    applyStimulus(1'b0, 8'h00, 1'b0, 2'b01, 4'b1111);
    checks++;
    if (bus.o_valid !== 4'b0010 || bus.o1 !== 8'h99 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_after: got valid=%b o1=%h busy=%b expected 0010 99 0", bus.o_valid, bus.o1, bus.busy);
    end
    advanceModel();
  endtask

`ifdef DEMUX_1X4_RR_EN
  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'h50 + 8'(k), 1'b1, 2'b11, 4'b1111);
      advanceModel();
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b11, 4'b1111);
      checks++;
      if (bus.o_valid !== (4'b0001 << (k % 4)) || outData(k % 4) !== 8'h50 + 8'(k)) begin
        errors++;
        $display("[TB] FAIL rr_%0d: got valid=%b data=%h expected %b %h", k, bus.o_valid, outData(k % 4), (4'b0001 << (k % 4)), 8'h50 + 8'(k));
      end
      advanceModel();
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] rdy;
    for (int c = 0; c < 400; c++) begin
      rdy = 4'($urandom) | 4'($urandom);
      applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 2) == 0),
                    2'($urandom), rdy);
      checks++;
      if (bus.i_ready !== expReady()) begin
        errors++;
        $display("[TB] FAIL rand_ready@%0d: got %b expected %b", c, bus.i_ready, expReady());
      end
      checks++;
      if (bus.o_valid !== mFull || bus.busy !== mOpen || (bus.o_last & mFull) !== (mLast & mFull)) begin
        errors++;
        $display("[TB] FAIL rand_flags@%0d: got valid=%b busy=%b last=%b expected %b %b %b", c, bus.o_valid, bus.busy, bus.o_last & mFull, mFull, mOpen, mLast & mFull);
      end
      for (int n = 0; n < 4; n++) begin
        if (mFull[n]) begin
          checks++;
          if (outData(n) !== mData[n]) begin
            errors++;
            $display("[TB] FAIL rand_data%0d@%0d: got %h expected %h", n, c, outData(n), mData[n]);
          end
        end
      end
      advanceModel();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetModel();
    test_reset();
`ifdef DEMUX_1X4_RR_EN
    test_round_robin();
`else
    test_single_beat();
    test_multi_beat();
    test_back_to_back();
    test_independent_drain();
    test_async_reset();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x4.md
DEMUX_1X4 -- requirements
Module: demux_1x4

Interface
REQ-001 Parameter WIDTH, default 8, data beat width in bits.
REQ-002 Ports: clk  input  1  rising-edge clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i0  input  WIDTH  inbound data beat.
REQ-005 i_valid  input  1  inbound beat present.
REQ-006 i_last  input  1  inbound beat is final beat of packet.
REQ-007 i_ready  output  1  block accepts inbound beat this cycle.
REQ-008 s1, s0  input  1 each  destination select: 00->o0, 01->o1, 10->o2, 11->o3.
REQ-009 o0, o1, o2, o3  output  WIDTH each  outbound data per destination.
REQ-010 o_valid  output  4  bit n = beat present on on.
REQ-011 o_last  output  4  bit n = beat on on is final beat of packet.
REQ-012 o_ready  input  4  bit n = consumer of on accepts this cycle.
REQ-013 busy  output  1  high while a multi-beat packet is open (state PKT).

Function
REQ-014 Accept: transfer occurs when i_valid & i_ready at posedge; outbound transfer on n when o_valid[n] & o_ready[n].
REQ-015 Each destination n holds one register slot {data, last, valid}.
REQ-016 i_ready = ~o_valid[dest] | o_ready[dest]; combinational; depends on no other destination.
REQ-017 FSM states IDLE, PKT; dest = {s1,s0} in IDLE, latched dest_q in PKT.
REQ-018 IDLE -> PKT on accept with i_last=0; dest_q <= {s1,s0} that cycle.
REQ-019 PKT -> IDLE on accept with i_last=1; accept with i_last=1 in IDLE stays IDLE (single-beat packet).
REQ-020 s1/s0 changes while in PKT are ignored; all beats of the packet go to dest_q.
REQ-021 Latency: beat accepted at edge k appears on o[dest] with o_valid[dest]=1 after edge k, i.e. one cycle.
REQ-022 Slot holds data/last/valid stable until drained; valid clears on drain without simultaneous refill.
REQ-023 Simultaneous drain and refill of same slot: new beat loaded, o_valid stays 1, no bubble.
REQ-024 Non-selected slots are unaffected by inbound traffic and drain independently.
REQ-025 i_valid low: no state change except draining; i0/i_last ignored.
REQ-026 No beat dropped or duplicated; beat order per destination preserved.

Reset
REQ-027 rst_n low: state IDLE, dest_q 0, o_valid 0000, o_last 0000, o0..o3 all zero, busy 0, immediately and independent of clk.
REQ-028 Reset mid-packet discards open packet and all slot contents; first accept after release is treated as start of packet.
REQ-029 i_ready is 1 during and after reset when i_valid is irrelevant (all slots empty).

Configuration
REQ-030 Macro DEMUX_1X4_RR_EN defined: s1/s0 ignored; destination of each new packet from 2-bit round-robin pointer, order o0,o1,o2,o3,o0...; pointer advances on accept with i_last=1; pointer resets to 0.
REQ-031 Macro undefined: destination from s1/s0 per REQ-008, REQ-017; no pointer logic present.

Verification
REQ-032 Reset then {s1,s0}=10, single beat i0=8'hA5 last=1, o_ready=1111 -> o2=A5, o_valid=0100, o_last=0100 one cycle later, busy stays 0.
REQ-033 3-beat packet 11,22,33 to o1, {s1,s0} toggled to 11 after beat 1 -> all three beats on o1, busy high from after beat 1 to after beat 3.
REQ-034 o_ready[0]=0, two beats to o0 -> first beat held on o0, i_ready=0 on second; o_ready[0]=1 -> back-to-back drain/refill, no bubble, no loss.
REQ-035 o3 stalled with full slot, packet to o0 -> o0 traffic flows, o3 data/valid unchanged.
REQ-036 rst_n asserted asynchronously mid-packet to o2 -> o_valid=0000, busy=0 before next edge; next packet routes per current s1/s0.
REQ-037 DEMUX_1X4_RR_EN defined, five single-beat packets with s1/s0=11 -> destinations o0,o1,o2,o3,o0.
